// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Request/response front end for the combinational 8-bit ALU. It accepts one
// operation over a valid/ready handshake and drives the ALU control and
// operand inputs. It captures the ALU result and returns it over a second
// valid/ready handshake. An unsigned multiply is built from repeated ALU adds
// (shift-add, low WIDTH bits kept).
//
// Configuration macro:
//   ALU_SEQ_MUL_EN  defined   -> op 4 performs the shift-add multiply
//                   undefined -> no multiply state or registers; op 4 is illegal
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   ReqValid/ReqReady        request handshake
//   ReqOp, ReqA, ReqB        operation (0 ADD, 1 SUB, 2 SLT, 3 SHL, 4 MUL) and
//                            operands; for SHL, A is the shift amount and B is
//                            the value shifted
//   RspValid/RspReady        response handshake
//   RspData, RspZero, RspErr result, result==0, illegal/unsupported op
//   ALUctl, ALUA, ALUB       drive to the ALU
//   ALUOut, ALUZero          result from the ALU

module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [2:0]       ReqOp,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RspZero,
    output logic             RspErr,
    output logic [1:0]       ALUctl,
    output logic [WIDTH-1:0] ALUA,
    output logic [WIDTH-1:0] ALUB,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             ALUZero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
`ifdef ALU_SEQ_MUL_EN
        S_MUL,
`endif
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            m_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
`endif
        ReqReady   = 1'b0;
        RspValid   = 1'b0;
        ALUctl     = '0;
        ALUA       = '0;
        ALUB       = '0;

        case (state_q)
            S_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    op_d = ReqOp[1:0];
                    a_d  = ReqA;
                    b_d  = ReqB;
                    if (ReqOp <= 3'd3) begin
                        state_d = S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                    end else if (ReqOp == 3'd4) begin
                        acc_d   = '0;
                        m_d     = ReqA;
                        q_d     = ReqB;
                        cnt_d   = '0;
                        state_d = S_MUL;
`endif
                    end else begin
                        rsp_data_d = '0;
                        rsp_zero_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end
                end
            end

            S_EXEC: begin
                ALUctl     = op_q;
                ALUA       = a_q;
                ALUB       = b_q;
                rsp_data_d = ALUOut;
                rsp_zero_d = ALUZero;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end

`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                // The ALU adds the shifted multiplicand onto the running sum;
                // the sum is only kept when the current multiplier bit is set.
                ALUctl = 2'd0;
                ALUA   = acc_q;
                ALUB   = m_q;
                if (q_q[0]) begin
                    acc_d = ALUOut;
                end
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + 1'b1;
                // Fixed WIDTH iterations, no early exit on q==0.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    rsp_data_d = acc_d;
                    rsp_zero_d = (acc_d == '0);
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end
            end
`endif

            S_RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign RspData = rsp_data_q;
    assign RspZero = rsp_zero_q;
    assign RspErr  = rsp_err_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle request/response front end that owns the 8-bit ALU's control side: it accepts an operation over a valid/ready handshake, drives the ALU's `ALUctl`/`A`/`B` inputs, captures `ALUOut`/`Zero`, and returns the result over a second valid/ready handshake. It also builds an 8×8 multiply out of repeated ALU adds, so datapath logic gets multiply without a dedicated multiplier. It sits between the datapath control and the combinational ALU instance.

## Interface

- `WIDTH`, 8, operand and result width; must equal the ALU width.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ReqValid`  in  1  request present.
- `ReqReady`  out  1  sequencer can accept a request.
- `ReqOp`  in  3  operation select:
  - 0 ADD, 1 SUB, 2 SLT, 3 SHL
  - 4 MUL
  - 5–7 illegal
- `ReqA`  in  WIDTH  operand A. For SHL, this is the shift amount; only `[3:0]` is used.
- `ReqB`  in  WIDTH  operand B. For SHL, this is the value shifted.
- `RspValid`  out  1  result present.
- `RspReady`  in  1  consumer takes the result.
- `RspData`  out  WIDTH  result.
- `RspZero`  out  1  result equals 0.
- `RspErr`  out  1  illegal or compiled-out op.
- `ALUctl`  out  2  to ALU.
- `ALUA`  out  WIDTH  to ALU `A`.
- `ALUB`  out  WIDTH  to ALU `B`.
- `ALUOut`  in  WIDTH  from ALU.
- `ALUZero`  in  1  from ALU `Zero`.

## Operation

- States: IDLE, EXEC, MUL, RESP.
- IDLE:
  - `ReqReady`=1.
  - On `ReqValid`, latch `ReqOp`/`ReqA`/`ReqB`.
  - Ops 0–3 go to EXEC.
  - Op 4 goes to MUL when enabled.
  - Op 5–7 (or op 4 disabled) go directly to RESP with `RspData`=0, `RspZero`=0, `RspErr`=1.
- EXEC:
  - Drive `ALUctl`=op[1:0], `ALUA`=latched A, `ALUB`=latched B.
  - At the end of the cycle, capture `RspData`←`ALUOut`, `RspZero`←`ALUZero`, `RspErr`←0.
  - Go to RESP.
- MUL (unsigned shift-add; low WIDTH bits of the product kept; overflow discarded silently):
  - Registers: acc (init 0), m (init A), q (init B), 3-bit count (init 0).
  - Each cycle drive `ALUctl`=0 (add), `ALUA`=acc, `ALUB`=m.
  - If q[0], acc←`ALUOut`.
  - Then m←m<<1, q←q>>1, count++.
  - After exactly 8 cycles (no early exit), capture `RspData`=final acc, `RspZero`=(final acc==0), `RspErr`=0.
  - Go to RESP.
- RESP:
  - `RspValid`=1.
  - `RspData`/`RspZero`/`RspErr` held stable until `RspValid`&&`RspReady`.
  - Then go to IDLE.
- `ReqReady` is 1 only in IDLE; no new request is accepted while a response is pending. No overlap, no buffering.
- Outside EXEC/MUL: `ALUctl`=0, `ALUA`=0, `ALUB`=0.
- SLT result is whatever the ALU returns (signed compare, 0 or 1). SHL is `ALUB << ALUA[3:0]` per the ALU.

## Timing

- Reset (`rst_n` low, async) values:
  - state IDLE, `ReqReady`=1
  - `RspValid`=0, `RspData`=0, `RspZero`=0, `RspErr`=0
  - `ALUctl`=0, `ALUA`=0, `ALUB`=0
  - MUL registers 0
- Request accepted at cycle T (`ReqValid`&&`ReqReady` at rising edge T):
  - ADD/SUB/SLT/SHL: EXEC in T+1, `RspValid` rises at T+2.
  - MUL: MUL in T+1..T+8, `RspValid` at T+9.
  - Illegal: `RspValid` at T+1.
- Response handshake at edge R returns to IDLE. `ReqReady`=1 in R+1; the earliest next accept is R+1. Minimum period is 3 cycles for ops 0–3.
- `ReqA`/`ReqB`/`ReqOp` are sampled only at accept; changes afterwards have no effect.
- `rst_n` asserted mid-EXEC/MUL/RESP: the operation is abandoned, outputs go to reset values immediately, and no response is produced.
- `RspReady` high while `RspValid`=0 is ignored.

## Configuration

- `ALU_SEQ_MUL_EN` defined: op 4 performs MUL as above (9-cycle latency).
- Undefined: MUL state and registers are not built; op 4 is treated as illegal (`RspErr`=1, `RspData`=0, `RspValid` at T+1).

## Test plan

- ADD:
  - A=0x7F, B=0x01 → `RspData`=0x80, `RspZero`=0, `RspErr`=0, `RspValid` at T+2, `ALUctl`=0 during T+1.
  - SUB A=0x05, B=0x05 → `RspData`=0x00, `RspZero`=1.
- SLT A=0xFF, B=0x01 → `RspData`=0x01. SHL A=0x03, B=0x11 → `RspData`=0x88.
- MUL (with `ALU_SEQ_MUL_EN`):
  - 0x0D×0x0B → `RspData`=0x8F, `RspValid` at T+9.
  - 0x10×0x10 → `RspData`=0x00, `RspZero`=1.
  - Without the macro, op 4 → `RspErr`=1, `RspData`=0, `RspValid` at T+1.
- Illegal op 6 → `RspErr`=1, `RspData`=0, `RspZero`=0, at T+1.
- Backpressure: hold `RspReady`=0 for 5 cycles after `RspValid` → `RspData`/`RspValid` stable, `ReqReady`=0 with `ReqValid` held high. After the handshake, the next request is accepted exactly one cycle later.
- Assert `rst_n`=0 during the 4th MUL cycle → all outputs reset values asynchronously. After release, ADD 0x02+0x03 → `RspData`=0x05 with no stale response.
